image_cell_loader: RTL and testbench

IMAGE_CELL_LOADER -- requirements
Module: image_cell_loader

---
 rtl/image_cell_loader.sv | 89 ++++++++
 tb/tb_image_cell_loader.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/image_cell_loader.sv
// image_cell_loader: collects an opcode plus two CELL_DIM x CELL_DIM pixel cells into one held instruction word
//   clk, reset_n           : clock, asynchronous active-low reset
//   cmd_valid/ready/opcode : opcode handshake, accepted only in IDLE
//   s_valid/ready/pixel    : row-major pixel stream, cellA then cellB; s_last marks the final cellB pixel
//   iw_valid/ready         : instruction word handshake towards the processor core
//   iw_opcode/cell_a/b     : captured opcode and cells; pixel [r][c] at bit (r*CELL_DIM+c)*PIXEL_W
//   frame_err              : one-cycle pulse when s_last does not line up with the final cellB pixel
module image_cell_loader #(
    parameter int CELL_DIM = 4,
    parameter int PIXEL_W  = 24,
    parameter int OPCODE_W = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               cmd_valid,
    input  logic [OPCODE_W-1:0]                cmd_opcode,
    output logic                               cmd_ready,
    input  logic                               s_valid,
    input  logic [PIXEL_W-1:0]                 s_pixel,
    input  logic                               s_last,
    output logic                               s_ready,
    output logic                               iw_valid,
    input  logic                               iw_ready,
    output logic [OPCODE_W-1:0]                iw_opcode,
    output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0] iw_cell_a,
    output logic [CELL_DIM*CELL_DIM*PIXEL_W-1:0] iw_cell_b,
    output logic                               frame_err
);
    localparam int CW = CELL_DIM > 1 ? $clog2(CELL_DIM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, ISSUE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] row, col;
    logic          beat, last_pos, bad;
    int            idx;

    assign cmd_ready = state == IDLE;
    assign s_ready   = state == LOAD_A || state == LOAD_B;
    assign iw_valid  = state == ISSUE;
    assign beat      = s_valid && s_ready;
    assign last_pos  = row == CW'(CELL_DIM - 1) && col == CW'(CELL_DIM - 1);
    assign idx       = int'(row) * CELL_DIM + int'(col);
    // s_last is legal only on the final cellB beat, and mandatory there
    assign bad       = beat && (state == LOAD_A ? s_last : s_last != last_pos);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? LOAD_A : IDLE;
            LOAD_A:  state_nx = bad ? IDLE : (beat && last_pos) ? LOAD_B : LOAD_A;
            LOAD_B:  state_nx = bad ? IDLE : (beat && last_pos) ? ISSUE : LOAD_B;
            default: state_nx = iw_ready ? IDLE : ISSUE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row       <= '0;
            col       <= '0;
            frame_err <= 1'b0;
            iw_opcode <= '0;
            iw_cell_a <= '0;
            iw_cell_b <= '0;
        end else begin
            frame_err <= bad;
            if (cmd_valid && cmd_ready)
                iw_opcode <= cmd_opcode;
            if (beat) begin
                if (state == LOAD_A) iw_cell_a[idx*PIXEL_W +: PIXEL_W] <= s_pixel;
                else                 iw_cell_b[idx*PIXEL_W +: PIXEL_W] <= s_pixel;
                if (bad || last_pos) begin
                    row <= '0;
                    col <= '0;
                end else if (col == CW'(CELL_DIM - 1)) begin
                    col <= '0;
                    row <= row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_image_cell_loader.sv
// tb_image_cell_loader: table-driven frames plus reset, backpressure and stall sequences
module tb_image_cell_loader;
    localparam int D = 4, PW = 24, OW = 3, N = D * D, CWD = N * PW;

    logic clk = 0, reset_n = 0, cmd_valid = 0, s_valid = 0, s_last = 0, iw_ready = 0;
    logic [OW-1:0] cmd_opcode = '0;
    logic [PW-1:0] s_pixel = '0;
    logic cmd_ready, s_ready, iw_valid, frame_err;
    logic [OW-1:0] iw_opcode;
    logic [CWD-1:0] iw_cell_a, iw_cell_b;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    image_cell_loader #(.CELL_DIM(D), .PIXEL_W(PW), .OPCODE_W(OW)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .cmd_ready(cmd_ready),
        .s_valid(s_valid), .s_pixel(s_pixel), .s_last(s_last), .s_ready(s_ready),
        .iw_valid(iw_valid), .iw_ready(iw_ready), .iw_opcode(iw_opcode),
        .iw_cell_a(iw_cell_a), .iw_cell_b(iw_cell_b), .frame_err(frame_err)
    );

    // last: 1-based beat carrying s_last (0 = never); rst_at: beats sent before reset (-1 = none)
    typedef struct {
        logic [OW-1:0] op;
        logic [PW-1:0] a_base, a_step, b_base, b_step;
        int            last;
        bit            stall;
        int            hold;
        int            rst_at;
        bit            exp_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(string nm, logic [CWD-1:0] act, logic [CWD-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] pix(vec_t v, int k);
        return k < N ? v.a_base + PW'(k) * v.a_step : v.b_base + PW'(k - N) * v.b_step;
    endfunction

    task automatic run(vec_t v);
        logic [CWD-1:0] ea, eb;
        int nb, stop;
        for (int k = 0; k < N; k++) begin
            ea[k*PW +: PW] = pix(v, k);
            eb[k*PW +: PW] = pix(v, k + N);
        end
        nb   = v.exp_err ? (v.last == 0 ? 2 * N : v.last) : 2 * N;
        stop = (v.rst_at >= 0 && v.rst_at < nb) ? v.rst_at : nb;
        @(negedge clk);
        chk("idle_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
        cmd_valid  = 1;
        cmd_opcode = v.op;
        @(negedge clk);
        cmd_valid  = 0;
        cmd_opcode = ~v.op;
        for (int k = 0; k < stop; k++) begin
            if (v.stall) repeat ($urandom_range(0, 2)) begin
                s_valid = 0;
                s_last  = 1;
                s_pixel = PW'($urandom);
                @(negedge clk);
            end
            chk("load_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b0100));
            s_valid = 1;
            s_pixel = pix(v, k);
            s_last  = (k + 1 == v.last);
            @(negedge clk);
        end
        s_valid = 0;
        s_last  = 0;
        if (v.rst_at >= 0) begin
            if (v.rst_at >= nb)
                chk("issue_before_rst", CWD'({cmd_ready, s_ready, iw_valid}), CWD'(3'b001));
            #2 reset_n = 0;
            #1;
            chk("rst_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
            chk("rst_cell_a", iw_cell_a, '0);
            @(negedge clk);
            reset_n = 1;
            repeat (2) @(negedge clk);
            chk("post_rst_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
        end else if (v.exp_err) begin
            chk("frame_err_hit", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1001));
            @(negedge clk);
            chk("frame_err_pulse", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
        end else begin
            chk("issue_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b0010));
            chk("iw_opcode", CWD'(iw_opcode), CWD'(v.op));
            chk("iw_cell_a", iw_cell_a, ea);
            chk("iw_cell_b", iw_cell_b, eb);
            repeat (v.hold) begin
                s_valid = 1;
                s_last  = 1;
                s_pixel = PW'($urandom);
                cmd_valid = 1;
                @(negedge clk);
                chk("hold_flags", CWD'({cmd_ready, s_ready, iw_valid, iw_opcode}), CWD'({3'b001, v.op}));
                chk("hold_cell_a", iw_cell_a, ea);
                chk("hold_cell_b", iw_cell_b, eb);
            end
            s_valid   = 0;
            s_last    = 0;
            cmd_valid = 0;
            iw_ready  = 1;
            @(negedge clk);
            iw_ready = 0;
            chk("released", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
        end
    endtask

    initial begin
        //          op    a_base    a_step    b_base    b_step   last stall hold rst err
        vecs[0] = '{3'd1, 24'h0,    24'h0,    24'h00FF00, 24'h0,    32, 0, 0,  -1, 0};
        vecs[1] = '{3'd2, 24'h0,    24'h1,    24'h100000, 24'h010101, 32, 0, 0, -1, 0};
        vecs[2] = '{3'd3, 24'h5,    24'h1,    24'h0,    24'h1,    20, 0, 0,  -1, 1};
        vecs[3] = '{3'd4, 24'h7,    24'h3,    24'h9,    24'h2,    0,  0, 0,  -1, 1};
        vecs[4] = '{3'd1, 24'h0,    24'h0,    24'h00FF00, 24'h0,    32, 1, 0,  -1, 0};
        vecs[5] = '{3'd5, 24'hABCDEF, 24'h111111, 24'hFFFFF0, 24'h1, 32, 0, 10, -1, 0};
        vecs[6] = '{3'd7, 24'h1,    24'h1,    24'h1,    24'h1,    1,  0, 0,  -1, 1};
        vecs[7] = '{3'd6, 24'h2,    24'h2,    24'h2,    24'h2,    16, 0, 0,  -1, 1};
        vecs[8] = '{3'd3, 24'hDEAD00, 24'h1,  24'hBEEF00, 24'h1,  32, 0, 0,  7,  0};
        vecs[9] = '{3'd6, 24'h123456, 24'h10101, 24'h654321, 24'h20202, 32, 1, 0, -1, 0};
        #3;
        chk("reset_flags", CWD'({cmd_ready, s_ready, iw_valid, frame_err}), CWD'(4'b1000));
        chk("reset_opcode", CWD'(iw_opcode), '0);
        chk("reset_cell_b", iw_cell_b, '0);
        @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 10; i++) run(vecs[i]);
        vecs[0].rst_at = 32;
        run(vecs[0]);
        run(vecs[1]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
